// File: rtl/neg_edge_detector_gate.sv
// neg_edge_detector_gate
//
// Synchronous falling-edge detector for a single-bit level signal. Each
// rising edge of clk compares the current sample of `a` with the sample
// taken at the previous edge; a 1->0 change produces a registered,
// one-cycle strobe on exp_out.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   reset    synchronous, active-high reset
//   a        monitored level, must already be synchronous to clk
//   exp_out  registered falling-edge strobe, high for one cycle per 1->0
//
// The history register resets to 0, so a line that is already low when
// reset releases is never reported as an edge; a 1 has to be seen first.

module neg_edge_detector_gate (
  input  logic clk,
  input  logic reset,
  input  logic a,
  output logic exp_out
);

  logic a_q;
  logic fall_det;

  // Previous sample high and current sample low.
  assign fall_det = a_q & ~a;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= 1'b0;
      exp_out <= 1'b0;
    end else begin
      exp_out <= fall_det;
      a_q     <= a;
    end
  end

endmodule

// File: tb/tb_neg_edge_detector_gate.sv
module tb_neg_edge_detector_gate;

  logic clk;
  logic reset;
  logic a;
  logic exp_out;

  int n_tests;
  int n_failed;

  // Reference history: values of `a` sampled at non-reset edges since the
  // last reset. A strobe is expected whenever the last two samples are 1,0.
  logic hist[$];
  logic model_exp;

  neg_edge_detector_gate dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .exp_out (exp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, update the
  // reference and compare 1 ns after the edge.
  task automatic step(input logic r, input logic av, input string tag);
    @(negedge clk);
    reset = r;
    a     = av;
    @(posedge clk);
    if (r) begin
      hist.delete();
      model_exp = 1'b0;
    end else begin
      hist.push_back(av);
      model_exp = (hist.size() >= 2) && hist[hist.size()-2] && !hist[hist.size()-1];
    end
    #1;
    check_bit(tag, exp_out, model_exp);
  endtask

  initial begin
    n_tests   = 0;
    n_failed  = 0;
    model_exp = 1'b0;
    reset     = 1'b1;
    a         = 1'b1;

    // Reset with a high, then release with a held high.
    @(posedge clk); #1;
    check_bit("reset_hold", exp_out, 1'b0);
    @(posedge clk); #1;
    check_bit("reset_hold2", exp_out, 1'b0);
    step(1'b0, 1'b1, "release_high");
    check_bit("release_first_edge", exp_out, 1'b0);
    step(1'b0, 1'b1, "high_steady");

    // Single falling edge: pulse for exactly one cycle, then quiet.
    step(1'b0, 1'b0, "fall1");
    check_bit("fall1_pulse", exp_out, 1'b1);
    step(1'b0, 1'b0, "fall1_end");
    check_bit("fall1_width", exp_out, 1'b0);

    // Repeated edges.
    step(1'b0, 1'b1, "rise2");
    step(1'b0, 1'b0, "fall2");
    check_bit("fall2_pulse", exp_out, 1'b1);
    step(1'b0, 1'b1, "rise3");
    check_bit("rise3_quiet", exp_out, 1'b0);
    step(1'b0, 1'b1, "rise3b");
    step(1'b0, 1'b0, "fall3");
    check_bit("fall3_pulse", exp_out, 1'b1);

    // Rising edge and static levels.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "static_low");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "static_high");

    // Alternating input: pulse every second cycle.
    for (int i = 0; i < 8; i++) step(1'b0, logic'(i % 2 == 0), "alternate");

    // Low during and after reset release: no pulse until a 1 is seen.
    step(1'b1, 1'b0, "low_reset");
    step(1'b1, 1'b0, "low_reset2");
    step(1'b0, 1'b0, "low_release");
    check_bit("low_release_quiet", exp_out, 1'b0);
    step(1'b0, 1'b0, "low_release2");
    step(1'b0, 1'b1, "low_then_high");
    step(1'b0, 1'b0, "low_then_fall");
    check_bit("late_fall_pulse", exp_out, 1'b1);

    // Reset mid-pulse, then release with a low.
    step(1'b0, 1'b1, "pre_mid");
    step(1'b0, 1'b0, "mid_pulse_set");
    check_bit("mid_pulse_set_hi", exp_out, 1'b1);
    step(1'b1, 1'b0, "mid_pulse_reset");
    check_bit("mid_pulse_cleared", exp_out, 1'b0);
    step(1'b0, 1'b0, "post_mid_release");
    step(1'b0, 1'b0, "post_mid_release2");
    check_bit("post_mid_quiet", exp_out, 1'b0);

    // Randomized stimulus with occasional resets and varying bias on a.
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic av;
      r  = ($urandom_range(0, 39) == 0);
      if (i < 200)      av = logic'($urandom_range(0, 1));
      else if (i < 400) av = ($urandom_range(0, 9) < 8);
      else              av = ($urandom_range(0, 9) < 2);
      step(r, av, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
